// File: rtl/regfile_master_pkg.sv
// Shared opcode constants and FSM state encoding for regfile_master.
package regfile_master_pkg;

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_RMW     = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_WAIT = 3'd3,
    S_WB   = 3'd4,
    S_RESP = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_master.sv
// Command-driven master for an external register file: WRITE, READ and
// read-modify-write ADD, with an error response for the illegal opcode.
//
// Handshakes: both command and response channels use strict valid/ready.
// A beat transfers on the rising edge where valid && ready are both 1.
// The command source holds Cmd_* stable while Cmd_Ready is 0; Cmd_Ready is
// only high in IDLE. Once Rsp_Valid rises it stays high, with Rsp_Data and
// Rsp_Err frozen, until the edge where Rsp_Ready is also high.
module regfile_master
  import regfile_master_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AddrW = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [1:0]       Cmd_Op,
  input  logic [AddrW-1:0] Cmd_Addr,
  input  logic [WIDTH-1:0] Cmd_Data,
  output logic             Rsp_Valid,
  input  logic             Rsp_Ready,
  output logic [WIDTH-1:0] Rsp_Data,
  output logic             Rsp_Err,
  output logic             RdEn,
  output logic             WrEn,
  output logic [AddrW-1:0] Address,
  output logic [WIDTH-1:0] WrData,
  input  logic [WIDTH-1:0] RdData
);

  // The address port must cover exactly the register file.
  if (DEPTH != 2 ** AddrW) begin : g_depth_check
    $error("regfile_master: DEPTH must equal 2**AddrW");
  end

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic [AddrW-1:0] r_addr;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_result;
  logic             r_err;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum;

  // Cmd_Ready is forced low while reset is asserted.
  assign Cmd_Ready = (r_state == S_IDLE) && !RST;
  assign w_accept  = Cmd_Valid && Cmd_Ready;
  // RMW sum wraps modulo 2**WIDTH; carry is discarded.
  assign w_sum     = r_result + r_data;

  // State register; reset drops any in-flight command.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (Cmd_Op)
            OP_WRITE: w_next = S_WR;
            OP_READ:  w_next = S_RD;
            OP_RMW:   w_next = S_RD;
            default:  w_next = S_RESP;
          endcase
        end
      end
      S_WR:    w_next = S_IDLE;
      S_RD:    w_next = S_WAIT;
      S_WAIT:  w_next = (r_op == OP_RMW) ? S_WB : S_RESP;
      S_WB:    w_next = S_RESP;
      S_RESP:  if (Rsp_Ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch and result register (read capture, RMW sum, error zero).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op     <= OP_WRITE;
      r_addr   <= '0;
      r_data   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= Cmd_Op;
        r_addr   <= Cmd_Addr;
        r_data   <= Cmd_Data;
        r_err    <= (Cmd_Op == OP_ILLEGAL);
        r_result <= '0;
      end
      if (r_state == S_WAIT) r_result <= RdData;
      if (r_state == S_WB)   r_result <= w_sum;
    end
  end

  // Strobes are pure state decodes, so RdEn and WrEn cannot overlap.
  assign RdEn      = (r_state == S_RD);
  assign WrEn      = (r_state == S_WR) || (r_state == S_WB);
  assign Address   = r_addr;
  assign WrData    = (r_state == S_WB) ? w_sum : r_data;
  assign Rsp_Valid = (r_state == S_RESP);
  assign Rsp_Data  = r_result;
  assign Rsp_Err   = r_err;

endmodule

// File: tb/tb_regfile_master.sv
// Directed and randomized checks for regfile_master against a bench-owned
// register file and an independent reference model of its contents.
module tb_regfile_master;
  import regfile_master_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AddrW = 3;

  logic             CLK;
  logic             RST;
  logic             Cmd_Valid;
  logic             Cmd_Ready;
  logic [1:0]       Cmd_Op;
  logic [AddrW-1:0] Cmd_Addr;
  logic [WIDTH-1:0] Cmd_Data;
  logic             Rsp_Valid;
  logic             Rsp_Ready;
  logic [WIDTH-1:0] Rsp_Data;
  logic             Rsp_Err;
  logic             RdEn;
  logic             WrEn;
  logic [AddrW-1:0] Address;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] RdData;

  int checks   = 0;
  int failures = 0;

  // register file environment with a bench backdoor for preloading
  logic [WIDTH-1:0] mem [DEPTH];
  logic             bd_we;
  logic [AddrW-1:0] bd_addr;
  logic [WIDTH-1:0] bd_data;

  // reference model of register contents and expected responses {err, data}
  logic [WIDTH-1:0] exp_mem [DEPTH];
  logic [WIDTH:0]   exp_q[$];

  regfile_master #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AddrW(AddrW)) dut (
    .CLK(CLK), .RST(RST),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Op(Cmd_Op),
    .Cmd_Addr(Cmd_Addr), .Cmd_Data(Cmd_Data),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Data(Rsp_Data),
    .Rsp_Err(Rsp_Err), .RdEn(RdEn), .WrEn(WrEn), .Address(Address),
    .WrData(WrData), .RdData(RdData)
  );

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // register file model: one-cycle read latency
  always @(posedge CLK) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (WrEn) mem[Address] <= WrData;
    if (RdEn) RdData <= mem[Address];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drive at a negedge; returns at the negedge of cycle t+1
  task automatic send_cmd(input logic [1:0] op, input logic [AddrW-1:0] a, input logic [WIDTH-1:0] d);
    Cmd_Valid = 1'b1;
    Cmd_Op    = op;
    Cmd_Addr  = a;
    Cmd_Data  = d;
    check("cmd_ready_at_accept", Cmd_Ready, 1);
    @(negedge CLK);
    Cmd_Valid = 1'b0;
  endtask

  task automatic bd_write(input logic [AddrW-1:0] a, input logic [WIDTH-1:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(negedge CLK);
    bd_we = 1'b0;
  endtask

  initial begin
    logic [1:0]       op;
    logic [AddrW-1:0] a;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   e;
    int               n;

    RST = 1'b1; Cmd_Valid = 1'b0; Cmd_Op = 2'b00; Cmd_Addr = '0;
    Cmd_Data = '0; Rsp_Ready = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    RdData = '0;
    for (int i = 0; i < DEPTH; i++) bd_write(AddrW'(i), '0);

    // reset values
    check("rst_cmd_ready", Cmd_Ready, 0);
    check("rst_rsp_valid", Rsp_Valid, 0);
    check("rst_rsp_err",   Rsp_Err,   0);
    check("rst_rden",      RdEn,      0);
    check("rst_wren",      WrEn,      0);
    check("rst_rsp_data",  Rsp_Data,  0);
    check("rst_address",   Address,   0);
    check("rst_wrdata",    WrData,    0);
    RST = 1'b0;
    #1;
    check("rst_release_ready", Cmd_Ready, 1);
    @(negedge CLK);

    // scenario 1: write then read
    send_cmd(OP_WRITE, 3'd3, 16'hABCD);
    check("s1_wren_t1",   WrEn,    1);
    check("s1_rden_t1",   RdEn,    0);
    check("s1_addr_t1",   Address, 3);
    check("s1_wrdata_t1", WrData,  16'hABCD);
    check("s1_busy_t1",   Cmd_Ready, 0);
    @(negedge CLK);
    check("s1_ready_t2",  Cmd_Ready, 1);
    check("s1_no_rsp_t2", Rsp_Valid, 0);
    send_cmd(OP_READ, 3'd3, 16'h0000);
    check("s1r_rden_t1", RdEn,    1);
    check("s1r_wren_t1", WrEn,    0);
    check("s1r_addr_t1", Address, 3);
    @(negedge CLK);
    check("s1r_rsp_t2",  Rsp_Valid, 0);
    check("s1r_addr_t2", Address, 3);
    @(negedge CLK);
    check("s1r_rsp_t3",  Rsp_Valid, 1);
    check("s1r_data_t3", Rsp_Data,  16'hABCD);
    check("s1r_err_t3",  Rsp_Err,   0);
    Rsp_Ready = 1'b1;
    @(negedge CLK);
    Rsp_Ready = 1'b0;
    check("s1r_idle_t4", Cmd_Ready, 1);
    check("s1r_rsp_t4",  Rsp_Valid, 0);

    // scenario 2: RMW with wrap
    bd_write(3'd5, 16'hFFFF);
    send_cmd(OP_RMW, 3'd5, 16'h0002);
    check("s2_rden_t1", RdEn,    1);
    check("s2_addr_t1", Address, 5);
    @(negedge CLK);
    check("s2_rden_t2", RdEn, 0);
    check("s2_wren_t2", WrEn, 0);
    @(negedge CLK);
    check("s2_wren_t3",   WrEn,    1);
    check("s2_rden_t3",   RdEn,    0);
    check("s2_wrdata_t3", WrData,  16'h0001);
    check("s2_addr_t3",   Address, 5);
    @(negedge CLK);
    check("s2_rsp_t4",  Rsp_Valid, 1);
    check("s2_data_t4", Rsp_Data,  16'h0001);
    check("s2_err_t4",  Rsp_Err,   0);
    check("s2_wren_t4", WrEn,      0);
    Rsp_Ready = 1'b1;
    @(negedge CLK);
    Rsp_Ready = 1'b0;
    check("s2_mem5",     mem[5],    16'h0001);
    check("s2_idle_t5",  Cmd_Ready, 1);

    // scenario 3: illegal opcode
    send_cmd(OP_ILLEGAL, 3'd2, 16'h1234);
    check("s3_rsp_t1",  Rsp_Valid, 1);
    check("s3_err_t1",  Rsp_Err,   1);
    check("s3_data_t1", Rsp_Data,  0);
    check("s3_rden_t1", RdEn,      0);
    check("s3_wren_t1", WrEn,      0);
    Rsp_Ready = 1'b1;
    @(negedge CLK);
    Rsp_Ready = 1'b0;
    check("s3_idle_t2", Cmd_Ready, 1);
    check("s3_rsp_t2",  Rsp_Valid, 0);
    check("s3_wren_t2", WrEn,      0);

    // scenario 4: response backpressure
    send_cmd(OP_READ, 3'd3, 16'h0000);
    @(negedge CLK);
    @(negedge CLK);
    for (int k = 0; k < 5; k++) begin
      check("s4_rsp_held",  Rsp_Valid, 1);
      check("s4_data_held", Rsp_Data,  16'hABCD);
      check("s4_err_held",  Rsp_Err,   0);
      check("s4_busy",      Cmd_Ready, 0);
      if (k < 4) @(negedge CLK);
    end
    Rsp_Ready = 1'b1;
    @(negedge CLK);
    Rsp_Ready = 1'b0;
    check("s4_idle_after", Cmd_Ready, 1);
    check("s4_rsp_after",  Rsp_Valid, 0);

    // scenario 5: reset during WAIT of an RMW
    bd_write(3'd6, 16'h1234);
    send_cmd(OP_RMW, 3'd6, 16'h0001);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("s5_cmd_ready", Cmd_Ready, 0);
    check("s5_rsp_valid", Rsp_Valid, 0);
    check("s5_rsp_err",   Rsp_Err,   0);
    check("s5_rden",      RdEn,      0);
    check("s5_wren",      WrEn,      0);
    check("s5_rsp_data",  Rsp_Data,  0);
    check("s5_address",   Address,   0);
    check("s5_wrdata",    WrData,    0);
    @(negedge CLK);
    check("s5_wren_rst2", WrEn, 0);
    RST = 1'b0;
    #1;
    check("s5_ready_release", Cmd_Ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("s5_no_wren", WrEn, 0);
    end
    check("s5_mem6_kept", mem[6], 16'h1234);

    // scenario 6: random command stream against the reference model
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = WIDTH'(16'h1111 * i);
      bd_write(AddrW'(i), exp_mem[i]);
    end
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = AddrW'($urandom_range(0, DEPTH - 1));
      d  = WIDTH'($urandom);
      send_cmd(op, a, d);
      case (op)
        OP_WRITE: exp_mem[a] = d;
        OP_READ:  exp_q.push_back({1'b0, exp_mem[a]});
        OP_RMW: begin
          s = exp_mem[a] + d;
          exp_mem[a] = s;
          exp_q.push_back({1'b0, s});
        end
        default:  exp_q.push_back({1'b1, {WIDTH{1'b0}}});
      endcase
      n = 0;
      while (!Cmd_Ready && n < 40) begin
        check("st_strobe_excl", RdEn & WrEn, 0);
        check("st_addr_stable", Address, a);
        Rsp_Ready = 1'($urandom_range(0, 1));
        if (Rsp_Valid && Rsp_Ready) begin
          if (exp_q.size() == 0) begin
            check("st_unexpected_rsp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("st_rsp_data", Rsp_Data, e[WIDTH-1:0]);
            check("st_rsp_err",  Rsp_Err,  e[WIDTH]);
          end
        end
        @(negedge CLK);
        n++;
      end
      check("st_cmd_done", Cmd_Ready, 1);
      if (!Cmd_Ready) break;
    end
    Rsp_Ready = 1'b0;
    check("st_rsp_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_master.md
REGFILE_MASTER -- requirements
Module: regfile_master

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- WIDTH, 16, data width.
- DEPTH, 8, register file entries.
- AddrW, 3, address width (DEPTH = 2**AddrW).

REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- Cmd_Valid  in  1  command present.
- Cmd_Ready  out  1  command accepted when Cmd_Valid && Cmd_Ready.
- Cmd_Op  in  2  00 WRITE, 01 READ, 10 RMW-ADD, 11 illegal.
- Cmd_Addr  in  AddrW  target register.
- Cmd_Data  in  WIDTH  write data or RMW addend.
- Rsp_Valid  out  1  response present.
- Rsp_Ready  in  1  response consumed when Rsp_Valid && Rsp_Ready.
- Rsp_Data  out  WIDTH  read value or RMW result; 0 on error.
- Rsp_Err  out  1  illegal opcode flag.
- RdEn  out  1  register file read strobe.
- WrEn  out  1  register file write strobe.
- Address  out  AddrW  register file address.
- WrData  out  WIDTH  register file write data.
- RdData  in  WIDTH  register file read data, valid the cycle after RdEn.

Function
REQ-003 FSM states SHALL be IDLE, WR, RD, WAIT, WB, RESP.
REQ-004 Cmd_Ready SHALL be 1 only in IDLE; on accept, op, addr and data SHALL be latched.
REQ-005 Transitions from IDLE on accept SHALL be: WRITE to WR; READ to RD; RMW to RD; illegal to RESP.
REQ-006 Other transitions SHALL be: WR to IDLE; RD to WAIT; WAIT to RESP (READ) or WB (RMW); WB to RESP; RESP to IDLE on Rsp_Valid && Rsp_Ready.
REQ-007 WrEn SHALL be 1 only in WR and WB; RdEn SHALL be 1 only in RD; both SHALL never be 1 in the same cycle, and each SHALL depend only on state.
REQ-008 Address SHALL equal the latched address from the cycle after accept until return to IDLE.
REQ-009 In WAIT, RdData SHALL be captured into the result register.
REQ-010 In WB, WrData SHALL be the captured value plus the latched addend, truncated to WIDTH bits (wraps modulo 2**WIDTH, no carry out); the result register SHALL take the same value.
REQ-011 In WR, WrData SHALL be the latched Cmd_Data.
REQ-012 Latencies, with accept at cycle t:
- WRITE: WrEn at t+1; Cmd_Ready high again at t+2; no response.
- READ: RdEn at t+1; Rsp_Valid at t+3.
- RMW: RdEn at t+1; WrEn at t+3; Rsp_Valid at t+4.
- Illegal: Rsp_Valid with Rsp_Err=1 at t+1; no RdEn or WrEn.
REQ-013 In RESP, Rsp_Valid, Rsp_Data and Rsp_Err SHALL be held stable until the handshake; Rsp_Ready SHALL be ignored outside RESP.
REQ-014 Rsp_Err SHALL be 0 for every legal opcode.
REQ-015 Commands presented while Cmd_Ready=0 SHALL be neither accepted nor lost; the source holds them.

Reset
REQ-016 While RST=1 at a clock edge, the state SHALL become IDLE.
REQ-017 While RST=1 at a clock edge, Rsp_Valid, Rsp_Err, RdEn and WrEn SHALL become 0.
REQ-018 While RST=1 at a clock edge, Rsp_Data, Address and WrData SHALL become 0.
REQ-019 Reset mid-operation SHALL drop the in-flight command; no WrEn SHALL follow a reset.
REQ-020 Cmd_Ready SHALL be 0 during reset and 1 in the first cycle after RST falls.

Structure
REQ-021 Opcode constants and the state encoding SHALL live in shared package regfile_master_pkg.
REQ-022 The block SHALL be a single module with no sub-module; the adder stays inline.

Verification
REQ-023 Scenario 1, write then read: WRITE addr 3 data 0xABCD, then READ addr 3 -> WrEn at t+1, Rsp_Data=0xABCD at t+3 of the read, Rsp_Err=0.
REQ-024 Scenario 2, RMW with wrap: addr 5 holds 0xFFFF; RMW addend 0x0002 -> WrData=0x0001 at t+3, Rsp_Data=0x0001 at t+4.
REQ-025 Scenario 3, illegal opcode: Cmd_Op=11 -> Rsp_Valid=1, Rsp_Err=1, Rsp_Data=0 at t+1; RdEn and WrEn stay 0.
REQ-026 Scenario 4, backpressure: READ with Rsp_Ready=0 for 5 cycles -> Rsp_Valid and Rsp_Data held; Cmd_Ready=0 throughout; IDLE one cycle after Rsp_Ready=1.
REQ-027 Scenario 5, reset mid-RMW: RST=1 during WAIT -> no WrEn, register content unchanged, all outputs 0, Cmd_Ready=1 the cycle after RST falls.
REQ-028 Scenario 6, strobe check: every cycle of a random 1000-command stream -> never RdEn && WrEn; Address stable from t+1 to completion of each command.
